// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage integer core.
// Drives hold/flush/load controls of pc_reg, if_id and id_ex. It resolves
// ex-stage jumps, load-use stalls, multi-cycle ex ops with a watchdog, and a
// debug halt. It also keeps stall and flush performance counters.
module pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_req_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              mc_start_i,
    input  logic              mc_done_i,
    input  logic              ld_use_i,
    input  logic              ext_halt_i,
    output logic              pc_hold_o,
    output logic              pc_load_o,
    output logic [31:0]       pc_load_addr_o,
    output logic              if_id_hold_o,
    output logic              if_id_flush_o,
    output logic              id_ex_hold_o,
    output logic              id_ex_flush_o,
    output logic              halted_o,
    output logic              mc_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    // Watchdog is 16 bits wide because MC_TIMEOUT is at most 65535.
    localparam logic [15:0] TIMEOUT_VAL = 16'(MC_TIMEOUT);

    state_t            state_q, state_d;
    logic [15:0]       wdog_q, wdog_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Combinational decode of pipeline controls and next state; all outputs are
    // forced low while rst is high so downstream registers see no action.
    always_comb begin
        state_d        = state_q;
        wdog_d         = wdog_q;
        pc_hold_o      = 1'b0;
        pc_load_o      = 1'b0;
        pc_load_addr_o = 32'd0;
        if_id_hold_o   = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_hold_o   = 1'b0;
        id_ex_flush_o  = 1'b0;
        mc_timeout_o   = 1'b0;
        if (!rst) begin
            pc_load_addr_o = jump_addr_i;
            unique case (state_q)
                RUN: begin
                    if (jump_req_i) begin
                        // Taken jump squashes the two younger instructions.
                        pc_load_o     = 1'b1;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (mc_start_i) begin
                        // A same-cycle completion needs no freeze at all.
                        if (!mc_done_i) begin
                            pc_hold_o    = 1'b1;
                            if_id_hold_o = 1'b1;
                            id_ex_hold_o = 1'b1;
                            state_d      = MC_WAIT;
                            wdog_d       = 16'd1;
                        end
                    end else if (ld_use_i) begin
                        // Freeze fetch/decode and push one bubble into ex.
                        pc_hold_o     = 1'b1;
                        if_id_hold_o  = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (ext_halt_i) begin
                        state_d = HALT;
                    end
                end
                MC_WAIT: begin
                    if (mc_done_i) begin
                        state_d = RUN;
                        wdog_d  = 16'd0;
                    end else if (wdog_q == TIMEOUT_VAL) begin
                        // Watchdog release: let the pipe advance regardless.
                        mc_timeout_o = 1'b1;
                        state_d      = RUN;
                        wdog_d       = 16'd0;
                    end else begin
                        pc_hold_o    = 1'b1;
                        if_id_hold_o = 1'b1;
                        id_ex_hold_o = 1'b1;
                        wdog_d       = wdog_q + 16'd1;
                    end
                end
                HALT: begin
                    // id_ex keeps receiving bubbles, so no jump can resolve.
                    pc_hold_o     = 1'b1;
                    if_id_hold_o  = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (!ext_halt_i) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    wdog_d  = 16'd0;
                end
            endcase
        end
    end

    // Next values of the registered status and wrapping performance counters.
    always_comb begin
        halted_d    = (state_d == HALT);
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_hold_o};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, pc_load_o};
    end

    // State, watchdog, halted flag and counters; synchronous reset to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wdog_q      <= 16'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. Each step drives one cycle of
// inputs, pushes the expected response to a scoreboard queue, then pops and
// compares it against the DUT away from the rising edge.
module tb_pipe_ctrl;

    localparam int MCT  = 6;
    localparam int CW   = 4;

    // Control vector order: pc_hold, pc_load, if_id_hold, if_id_flush,
    // id_ex_hold, id_ex_flush, mc_timeout.
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_JMP  = 7'b0101010;
    localparam logic [6:0] C_HOLD = 7'b1010100;
    localparam logic [6:0] C_LDU  = 7'b1010010;
    localparam logic [6:0] C_HALT = 7'b1010010;
    localparam logic [6:0] C_TOUT = 7'b0000001;

    typedef struct {
        logic [6:0]    ctrl;
        logic [31:0]   addr;
        logic          halted;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           jump_req_i;
    logic [31:0]    jump_addr_i;
    logic           mc_start_i;
    logic           mc_done_i;
    logic           ld_use_i;
    logic           ext_halt_i;
    logic           pc_hold_o;
    logic           pc_load_o;
    logic [31:0]    pc_load_addr_o;
    logic           if_id_hold_o;
    logic           if_id_flush_o;
    logic           id_ex_hold_o;
    logic           id_ex_flush_o;
    logic           halted_o;
    logic           mc_timeout_o;
    logic [CW-1:0]  stall_cnt_o;
    logic [CW-1:0]  flush_cnt_o;

    exp_t           sb[$];
    int             n_cmp;
    int             n_fail;
    int             step_no;
    logic [CW-1:0]  stall_m;
    logic [CW-1:0]  flush_m;

    pipe_ctrl #(
        .MC_TIMEOUT (MCT),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .mc_start_i     (mc_start_i),
        .mc_done_i      (mc_done_i),
        .ld_use_i       (ld_use_i),
        .ext_halt_i     (ext_halt_i),
        .pc_hold_o      (pc_hold_o),
        .pc_load_o      (pc_load_o),
        .pc_load_addr_o (pc_load_addr_o),
        .if_id_hold_o   (if_id_hold_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_hold_o   (id_ex_hold_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .halted_o       (halted_o),
        .mc_timeout_o   (mc_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, expv);
        end
    endtask

    // One cycle: drive inputs, queue expectation, compare at the falling edge.
    task automatic step(input logic r, input logic j, input logic [31:0] a,
                        input logic ms, input logic md, input logic ld,
                        input logic eh, input logic [6:0] ec, input logic eh_o);
        exp_t e;
        exp_t got;
        logic [6:0] obs_ctrl;
        rst         = r;
        jump_req_i  = j;
        jump_addr_i = a;
        mc_start_i  = ms;
        mc_done_i   = md;
        ld_use_i    = ld;
        ext_halt_i  = eh;
        e.ctrl   = r ? C_NONE : ec;
        e.addr   = r ? 32'd0 : a;
        e.halted = eh_o;
        e.stall  = stall_m;
        e.flush  = flush_m;
        sb.push_back(e);
        @(negedge clk);
        step_no++;
        obs_ctrl = {pc_hold_o, pc_load_o, if_id_hold_o, if_id_flush_o,
                    id_ex_hold_o, id_ex_flush_o, mc_timeout_o};
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end else begin
            got = sb.pop_front();
            check("ctrl",   32'(obs_ctrl),    32'(got.ctrl));
            check("addr",   pc_load_addr_o,   got.addr);
            check("halted", 32'(halted_o),    32'(got.halted));
            check("stall",  32'(stall_cnt_o), 32'(got.stall));
            check("flush",  32'(flush_cnt_o), 32'(got.flush));
            $display("step %0d rst=%0b ctrl=%b addr=%h halted=%0b stall=%0d flush=%0d",
                     step_no, r, obs_ctrl, pc_load_addr_o, halted_o, stall_cnt_o, flush_cnt_o);
        end
        if (r) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
            if (e.ctrl[6]) stall_m = stall_m + 1'b1;
            if (e.ctrl[5]) flush_m = flush_m + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        step_no = 0;
        stall_m = '0;
        flush_m = '0;

        // Unchecked first reset cycle brings the registers out of X.
        rst = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF;
        mc_start_i = 1'b1; mc_done_i = 1'b1; ld_use_i = 1'b1; ext_halt_i = 1'b1;
        @(posedge clk);
        #1;

        // Reset with every input high: everything reads zero.
        for (int i = 0; i < 3; i++)
            step(1, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Jump, then jump with competing requests.
        step(0, 1, 32'h0000_0100, 0, 0, 0, 0, C_JMP, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);
        step(0, 1, 32'h0000_0200, 1, 0, 1, 1, C_JMP, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Load-use for two cycles.
        step(0, 0, 32'd0, 0, 0, 1, 0, C_LDU, 0);
        step(0, 0, 32'd0, 0, 0, 1, 0, C_LDU, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Multi-cycle op finishing in the start cycle: no freeze.
        step(0, 0, 32'd0, 1, 1, 0, 0, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Multi-cycle op, done 5 cycles after start; jump/ld_use ignored inside.
        step(0, 0, 32'd0, 1, 0, 0, 0, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_HOLD, 0);
        step(0, 1, 32'h0000_0300, 0, 0, 1, 1, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 1, 0, 0, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Watchdog: no done, release pulse in the MCT-th wait cycle.
        step(0, 0, 32'd0, 1, 0, 0, 0, C_HOLD, 0);
        for (int i = 1; i < MCT; i++)
            step(0, 0, 32'd0, 0, 0, 0, 0, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_TOUT, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Reset in the 2nd wait cycle: back in RUN, no pulse afterwards.
        step(0, 0, 32'd0, 1, 0, 0, 0, C_HOLD, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_HOLD, 0);
        step(1, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);
        for (int i = 0; i < MCT + 1; i++)
            step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Halt for 6 cycles; a stray jump while halted is ignored.
        step(0, 0, 32'd0, 0, 0, 0, 1, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 0, 1, C_HALT, 1);
        step(0, 1, 32'h0000_0400, 0, 0, 0, 1, C_HALT, 1);
        step(0, 0, 32'd0, 0, 0, 0, 1, C_HALT, 1);
        step(0, 0, 32'd0, 0, 0, 0, 1, C_HALT, 1);
        step(0, 0, 32'd0, 0, 0, 0, 1, C_HALT, 1);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_HALT, 1);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        // Stall counter to 15, then one more stall wraps it to 0.
        for (int i = 0; i < 9; i++)
            step(0, 0, 32'd0, 0, 0, 1, 0, C_LDU, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);
        step(0, 0, 32'd0, 0, 0, 1, 0, C_LDU, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, C_NONE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the 5-stage integer core. It sits beside pc_reg, if_id and id_ex and drives their hold/flush/load controls. It resolves ex-stage jumps, id-stage load-use stalls, multi-cycle ex operations (with a watchdog) and an external debug halt. It also keeps stall and flush performance counters.

## Interface
- MC_TIMEOUT, default 64: maximum cycles spent in MC_WAIT before a forced release; legal range 2..65535.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- jump_req_i  in  1  ex resolved a taken branch or jump this cycle.
- jump_addr_i  in  32  target address for jump_req_i.
- mc_start_i  in  1  ex holds a multi-cycle op (div/mul) that starts this cycle.
- mc_done_i  in  1  multi-cycle op result is valid this cycle.
- ld_use_i  in  1  id detected a load-use dependency on the instruction in ex.
- ext_halt_i  in  1  debug halt request, level-sensitive.
- pc_hold_o  out  1  pc_reg keeps its value.
- pc_load_o  out  1  pc_reg loads pc_load_addr_o next edge.
- pc_load_addr_o  out  32  jump target (equals jump_addr_i).
- if_id_hold_o  out  1  if_id keeps its contents.
- if_id_flush_o  out  1  if_id loads a NOP (flush wins over hold).
- id_ex_hold_o  out  1  id_ex keeps its contents.
- id_ex_flush_o  out  1  id_ex loads a bubble (rd_wen=0, NOP).
- halted_o  out  1  registered; 1 while in HALT.
- mc_timeout_o  out  1  one-cycle pulse on watchdog release.
- stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1.
- flush_cnt_o  out  CNT_W  number of accepted jumps.

## Operation
- FSM states: RUN, MC_WAIT, HALT. Reset state is RUN.
- While rst=1:
  - all control outputs are 0, and mc_timeout_o=0, halted_o=0;
  - both counters clear to 0 and the watchdog counter clears to 0.
- Decode is combinational from the current state and inputs. In RUN, priority is jump > mc_start > ld_use > halt:
  - jump_req_i: pc_load_o=1, pc_load_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. flush_cnt_o increments. Stay in RUN. Any simultaneous mc_start_i, ld_use_i or ext_halt_i is ignored this cycle.
  - mc_start_i: pc_hold_o, if_id_hold_o and id_ex_hold_o are all 1. Next state is MC_WAIT and the watchdog counter loads 1. If mc_done_i is also 1 in the same cycle, all holds are 0 and the state stays RUN.
  - ld_use_i: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1. This inserts one bubble per asserted cycle. Stay in RUN.
  - ext_halt_i: no control asserted this cycle. Next state is HALT.
- MC_WAIT:
  - pc_hold_o, if_id_hold_o and id_ex_hold_o are all 1, and the watchdog counter increments.
  - mc_done_i=1: all holds are 0 this cycle and the next state is RUN.
  - No mc_done_i and watchdog==MC_TIMEOUT: all holds are 0, mc_timeout_o=1, next state RUN.
  - jump_req_i, ld_use_i and ext_halt_i are ignored. ext_halt_i, being a level, is re-sampled in RUN.
- HALT:
  - pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1.
  - ext_halt_i=0 returns to RUN on the next edge.
  - jump_req_i cannot occur, since id_ex holds a bubble; if it is asserted anyway, it is ignored.
- Counters:
  - stall_cnt_o increments by 1 on each edge where pc_hold_o=1.
  - flush_cnt_o increments by 1 on each edge where pc_load_o=1.
  - Both wrap from 2^CNT_W-1 to 0. No saturation.

## Timing
- Jump, stall, flush and hold outputs are combinational, with zero-cycle latency from their inputs. Registers downstream act on the same rising edge.
- halted_o and the FSM state are registered. halted_o rises one cycle after ext_halt_i is sampled in RUN and falls one cycle after ext_halt_i drops.
- mc_timeout_o is combinational in the release cycle and is exactly 1 cycle wide.
- Counter outputs are registered and lag the event by 1 cycle.
- Maximum MC_WAIT residency: MC_TIMEOUT cycles, not counting the entry cycle in RUN.
- rst asserted mid-MC_WAIT or mid-HALT: the next state is RUN, the watchdog is cleared, and no mc_timeout_o pulse is produced.

## Test plan
- Reset: hold rst=1 for 3 cycles with all inputs at 1 -> all outputs 0, both counters 0; after release with inputs at 0, the state is RUN.
- Jump: jump_req_i=1 with jump_addr_i=32'h0000_0100 for 1 cycle.
  - Same cycle: pc_load_o=1, pc_load_addr_o=32'h100, if_id_flush_o=1, id_ex_flush_o=1.
  - flush_cnt_o reads 1 on the next cycle.
  - Repeat with ld_use_i=1 and mc_start_i=1 simultaneous -> only the jump controls assert.
- Load-use: ld_use_i=1 for 2 cycles -> pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 in both cycles; stall_cnt_o ends at 2.
- Multi-cycle: mc_start_i pulse, then mc_done_i asserted 5 cycles later.
  - Holds=1 for the start cycle plus 4 MC_WAIT cycles.
  - Holds=0 in the done cycle, with the state back in RUN after it.
  - stall_cnt_o=5, mc_timeout_o never asserts.
- Watchdog: MC_TIMEOUT=4, mc_start_i pulse, mc_done_i never asserted.
  - mc_timeout_o pulses exactly once, in the 4th MC_WAIT cycle, with holds=0 in that cycle.
  - stall_cnt_o=4.
  - Separately, assert rst in the 2nd MC_WAIT cycle -> no pulse, and the state is RUN.
- Halt: ext_halt_i=1 for 6 cycles -> halted_o=1 from cycle 2 through cycle 7, with pc_hold_o=1 while halted.
  - Then with CNT_W=4 preloaded to 15 by stalls, one more stall -> stall_cnt_o wraps to 0.
